// File: rtl/lfsr_par_checker.sv
// ----------------------------------------------------------------------------
// lfsr_par_checker
// Receive side of the 4-bit LFSR + even-parity test stream. Locks a local
// LFSR (x^4+x^3+1, shift left) onto the incoming words. Once locked it
// flywheels and flags every word that does not match.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active low
//   din      : received LFSR word
//   par_in   : received even-parity bit (expected ^din)
//   din_vld  : din/par_in valid; all state advances only when high
//   err_clr  : synchronous clear of err_cnt (wins over increment)
//   locked   : high while in LOCK
//   err      : one-cycle pulse, previous valid word failed while locked
//   err_cnt  : saturating count of err pulses
// ----------------------------------------------------------------------------
module lfsr_par_checker #(
    parameter int unsigned N_SYNC = 3,
    parameter int unsigned N_LOSS = 2,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       din,
    input  logic             par_in,
    input  logic             din_vld,
    input  logic             err_clr,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned WORD_W = 4;
    localparam int unsigned RUN_W  = 4;

    localparam logic [RUN_W-1:0]  SYNC_TGT = RUN_W'(N_SYNC);
    localparam logic [RUN_W-1:0]  LOSS_TGT = RUN_W'(N_LOSS);
    localparam logic [WORD_W-1:0] SEED     = WORD_W'(1);
    localparam logic [ERR_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WORD_W-1:0]  pred;
    logic [WORD_W-1:0]  pred_nxt;
    logic [RUN_W-1:0]   run;
    logic [RUN_W-1:0]   run_nxt;
    logic               err_nxt;

    logic               par_ok_c;
    logic               seed_ok_c;
    logic               good_c;
    logic [RUN_W-1:0]   run_inc_c;

    // One step of the x^4+x^3+1 shift-left LFSR.
    function automatic logic [WORD_W-1:0] lfsr_next(input logic [WORD_W-1:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

    // Word qualification: a seed needs only good parity and a legal (non-zero)
    // value; a good word must also match the local prediction.
    assign par_ok_c  = ((^din) == par_in);
    assign seed_ok_c = par_ok_c && (din != '0);
    assign good_c    = din_vld && seed_ok_c && (din == pred);
    assign run_inc_c = run + RUN_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HUNT;
            pred  <= SEED;
            run   <= '0;
        end else begin
            state <= state_nxt;
            pred  <= pred_nxt;
            run   <= run_nxt;
        end
    end

    // Next-state logic; nothing moves on invalid cycles.
    always_comb begin
        state_nxt = state;
        pred_nxt  = pred;
        run_nxt   = run;
        err_nxt   = 1'b0;
        if (din_vld) begin
            unique case (state)
                HUNT: begin
                    if (seed_ok_c) begin
                        pred_nxt  = lfsr_next(din);
                        run_nxt   = '0;
                        state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (good_c) begin
                        pred_nxt = lfsr_next(pred);
                        if (run_inc_c == SYNC_TGT) begin
                            state_nxt = LOCK;
                            run_nxt   = '0;
                        end else begin
                            run_nxt = run_inc_c;
                        end
                    end else if (seed_ok_c) begin
                        // Mismatch with a plausible word: reseed in place.
                        pred_nxt = lfsr_next(din);
                        run_nxt  = '0;
                    end else begin
                        state_nxt = HUNT;
                        run_nxt   = '0;
                    end
                end
                LOCK: begin
                    // Flywheel: prediction advances regardless of what arrives.
                    pred_nxt = lfsr_next(pred);
                    if (good_c) begin
                        run_nxt = '0;
                    end else begin
                        err_nxt = 1'b1;
                        if (run_inc_c == LOSS_TGT) begin
                            state_nxt = HUNT;
                            run_nxt   = '0;
                        end else begin
                            run_nxt = run_inc_c;
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    run_nxt   = '0;
                end
            endcase
        end
    end

    // Registered status outputs; err_cnt counts on the same edge err is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            locked <= (state_nxt == LOCK);
            err    <= err_nxt;
            if (err_clr) begin
                err_cnt <= '0;
            end else if (err_nxt && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lfsr_par_checker.sv
// ----------------------------------------------------------------------------
// tb_lfsr_par_checker
// Drives two checker instances (ERR_W=8 and ERR_W=2) with the same stream:
// directed scenarios followed by a randomized stream with faults, checking
// every cycle against a table-driven behavioural model.
// ----------------------------------------------------------------------------
module tb_lfsr_par_checker;

    localparam int unsigned N_SYNC = 3;
    localparam int unsigned N_LOSS = 2;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       par_in;
    logic       din_vld;
    logic       err_clr;
    logic       locked_a, err_a;
    logic [7:0] err_cnt_a;
    logic       locked_b, err_b;
    logic [1:0] err_cnt_b;

    lfsr_par_checker #(.N_SYNC(N_SYNC), .N_LOSS(N_LOSS), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst), .din(din), .par_in(par_in), .din_vld(din_vld),
        .err_clr(err_clr), .locked(locked_a), .err(err_a), .err_cnt(err_cnt_a)
    );

    lfsr_par_checker #(.N_SYNC(N_SYNC), .N_LOSS(N_LOSS), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .din(din), .par_in(par_in), .din_vld(din_vld),
        .err_clr(err_clr), .locked(locked_b), .err(err_b), .err_cnt(err_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference sequence from seed 0001.
    logic [3:0] ref_seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    int n_vec;
    int n_fail;

    // Behavioural model: mode 0=hunting, 1=syncing, 2=locked.
    int         m_mode;
    logic [3:0] m_pred;
    int         m_run;
    int         m_err;
    int         m_cnt_a;
    int         m_cnt_b;
    int         tx;

    function automatic logic [3:0] succ(input logic [3:0] w);
        for (int i = 0; i < 15; i++)
            if (ref_seq[i] == w) return ref_seq[(i + 1) % 15];
        return 4'h0;
    endfunction

    function automatic bit even_par(input logic [3:0] w);
        return bit'($countones(w) % 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pred = 4'h1; m_run = 0; m_err = 0; m_cnt_a = 0; m_cnt_b = 0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] d, input bit p, input bit c);
        bit par_ok, plausible, good;
        m_err = 0;
        if (v) begin
            par_ok    = (even_par(d) == p);
            plausible = par_ok && (d != 4'h0);
            good      = plausible && (d == m_pred);
            if (m_mode == 0) begin
                if (plausible) begin m_pred = succ(d); m_run = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (good) begin
                    m_pred = succ(m_pred);
                    m_run++;
                    if (m_run == int'(N_SYNC)) begin m_mode = 2; m_run = 0; end
                end else if (plausible) begin
                    m_pred = succ(d); m_run = 0;
                end else begin
                    m_mode = 0; m_run = 0;
                end
            end else begin
                m_pred = succ(m_pred);
                if (good) m_run = 0;
                else begin
                    m_err = 1;
                    m_run++;
                    if (m_run == int'(N_LOSS)) begin m_mode = 0; m_run = 0; end
                end
            end
        end
        if (c) begin m_cnt_a = 0; m_cnt_b = 0; end
        else if (m_err == 1) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".locked"},  32'(locked_a),  32'(m_mode == 2));
        check({tag, ".err"},     32'(err_a),     32'(m_err));
        check({tag, ".cnt8"},    32'(err_cnt_a), 32'(m_cnt_a));
        check({tag, ".locked2"}, 32'(locked_b),  32'(m_mode == 2));
        check({tag, ".cnt2"},    32'(err_cnt_b), 32'(m_cnt_b));
    endtask

    // Present one input vector, clock it, sample 1 time unit after the edge.
    task automatic cycle(input string tag, input bit v, input logic [3:0] d,
                         input bit p, input bit c);
        din_vld = v; din = d; par_in = p; err_clr = c;
        @(posedge clk);
        model_step(v, d, p, c);
        #1;
        check_all(tag);
    endtask

    task automatic send_good(input string tag);
        cycle(tag, 1'b1, ref_seq[tx], even_par(ref_seq[tx]), 1'b0);
        tx = (tx + 1) % 15;
    endtask

    // Asynchronous reset between edges; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_fail = 0; tx = 0;
        rst = 1'b0; din = '0; par_in = 1'b0; din_vld = 1'b0; err_clr = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1: clean stream, lock on 4th word, no errors.
        for (int i = 0; i < 30; i++) begin
            send_good("s1");
            check("s1.lock_point", 32'(locked_a), 32'(i >= 3));
        end

        // 2: flipped parity on 1001 while locked.
        while (tx != 3) send_good("s2.pre");
        cycle("s2.bad", 1'b1, 4'h9, 1'b1, 1'b0);
        tx = 4;
        check("s2.err", 32'(err_a), 32'd1);
        check("s2.cnt", 32'(err_cnt_a), 32'd1);
        check("s2.locked", 32'(locked_a), 32'd1);
        send_good("s2.post");
        check("s2.post_err", 32'(err_a), 32'd0);

        // 3: skip one word -> two errors, lose lock, relock after 4 words.
        while (tx != 2) send_good("s3.pre");
        send_good("s3.0100");
        tx = 4;
        send_good("s3.miss1");
        check("s3.err1", 32'(err_a), 32'd1);
        send_good("s3.miss2");
        check("s3.err2", 32'(err_a), 32'd1);
        check("s3.unlock", 32'(locked_a), 32'd0);
        for (int i = 0; i < 4; i++) send_good("s3.relock");
        check("s3.relocked", 32'(locked_a), 32'd1);
        check("s3.cnt", 32'(err_cnt_a), 32'd3);

        // 4: din_vld toggling; lock point counted in valid words.
        async_reset("s4.rst");
        tx = 0;
        for (int i = 0; i < 8; i++) begin
            send_good("s4.v");
            check("s4.lock_point", 32'(locked_a), 32'(i >= 3));
            cycle("s4.idle", 1'b0, 4'($urandom), 1'($urandom), 1'b0);
            check("s4.idle_hold", 32'(locked_a), 32'(i >= 3));
        end

        // 5: 0000 ignored in HUNT; 0110 seeds, 1101 expected next.
        async_reset("s5.rst");
        cycle("s5.zero", 1'b1, 4'h0, 1'b0, 1'b0);
        cycle("s5.seed", 1'b1, 4'h6, 1'b0, 1'b0);
        tx = 6;
        for (int i = 0; i < 3; i++) send_good("s5.sync");
        check("s5.locked", 32'(locked_a), 32'd1);

        // 6: saturation of 2-bit counter, clear priority, mid-word reset.
        for (int i = 0; i < 5; i++) begin
            cycle("s6.bad", 1'b1, ref_seq[tx], ~even_par(ref_seq[tx]), 1'b0);
            tx = (tx + 1) % 15;
            send_good("s6.good");
        end
        check("s6.sat2", 32'(err_cnt_b), 32'd3);
        check("s6.cnt8", 32'(err_cnt_a), 32'd5);
        cycle("s6.clr", 1'b1, ref_seq[tx], ~even_par(ref_seq[tx]), 1'b1);
        tx = (tx + 1) % 15;
        check("s6.clr_err", 32'(err_a), 32'd1);
        check("s6.clr_cnt", 32'(err_cnt_b), 32'd0);
        send_good("s6.good2");
        cycle("s6.bad2", 1'b1, ref_seq[tx], ~even_par(ref_seq[tx]), 1'b0);
        tx = (tx + 1) % 15;
        din_vld = 1'b1; din = ref_seq[tx]; par_in = even_par(ref_seq[tx]);
        async_reset("s6.async");
        check("s6.async_locked", 32'(locked_a), 32'd0);
        check("s6.async_err", 32'(err_a), 32'd0);
        check("s6.async_cnt", 32'(err_cnt_a), 32'd0);

        // Randomized stream with faults, idle cycles, clears and resets.
        tx = $urandom_range(0, 14);
        for (int i = 0; i < 600; i++) begin
            int kind;
            kind = int'($urandom_range(0, 99));
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd.rst");
            end else if ($urandom_range(0, 3) == 0) begin
                cycle("rnd.idle", 1'b0, 4'($urandom), 1'($urandom), 1'($urandom_range(0, 29) == 0));
            end else if (kind < 80) begin
                cycle("rnd.good", 1'b1, ref_seq[tx], even_par(ref_seq[tx]),
                      1'($urandom_range(0, 39) == 0));
                tx = (tx + 1) % 15;
            end else if (kind < 86) begin
                cycle("rnd.par", 1'b1, ref_seq[tx], ~even_par(ref_seq[tx]), 1'b0);
                tx = (tx + 1) % 15;
            end else if (kind < 92) begin
                tx = (tx + 1) % 15;
            end else if (kind < 95) begin
                cycle("rnd.zero", 1'b1, 4'h0, 1'($urandom), 1'b0);
            end else begin
                logic [3:0] w;
                w = 4'($urandom);
                cycle("rnd.junk", 1'b1, w, even_par(w), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
